// File: rtl/tvip_apb_arbiter.sv
// Round-robin arbiter that funnels N requesters onto one APB master port.
// The granted command is latched straight into the APB output registers, so
// requester-side changes after the grant cannot disturb an ongoing transfer.
// Completion (done/rdata/slverr) is combinational in the completing ACCESS cycle.
module tvip_apb_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic [N-1:0]        req,
    input  logic [N*AW-1:0]     req_addr,
    input  logic [N-1:0]        req_write,
    input  logic [N*DW-1:0]     req_wdata,
    input  logic [N*DW/8-1:0]   req_strb,
    input  logic [N*3-1:0]      req_prot,
    output logic [N-1:0]        done,
    output logic [DW-1:0]       rdata,
    output logic                slverr,
    output logic                psel,
    output logic                penable,
    output logic [AW-1:0]       paddr,
    output logic [2:0]          pprot,
    output logic                pwrite,
    output logic [DW-1:0]       pwdata,
    output logic [DW/8-1:0]     pstrb,
    input  logic                pready,
    input  logic [DW-1:0]       prdata,
    input  logic                pslverr
);

    localparam int unsigned SW = DW / 8;
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // Count value seen in the stalled cycle that makes the total reach TIMEOUT.
    localparam logic [CW-1:0] WAIT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] owner_q;
    logic [CW-1:0] wait_q;
    logic [N-1:0]  req_mask;
    logic [PW-1:0] winner;
    logic [PW-1:0] winner_inc;
    logic          grant_any;
    logic          grant;
    logic          complete;
    logic          timeout_hit;

    assign timeout_hit = (TIMEOUT > 0) && (state_q == ACCESS) && !pready
                         && (wait_q == WAIT_LAST);
    assign complete    = (state_q == ACCESS) && (pready || timeout_hit);

    // The owner still holds req in its completion cycle; keep it out of the next grant.
    always_comb begin
        req_mask = req;
        if (state_q == ACCESS) begin
            req_mask[owner_q] = 1'b0;
        end
    end

    // Round-robin scan: first asserted request at ptr, ptr+1, ... modulo N.
    always_comb begin
        int            sum;
        logic [PW-1:0] idx;
        grant_any = 1'b0;
        winner    = '0;
        sum       = 0;
        idx       = '0;
        // Scan from the far end so the closest request to ptr is written last.
        for (int i = int'(N) - 1; i >= 0; i--) begin
            sum = int'(ptr_q) + i;
            if (sum >= int'(N)) begin
                sum = sum - int'(N);
            end
            idx = PW'(sum);
            if (req_mask[idx]) begin
                grant_any = 1'b1;
                winner    = idx;
            end
        end
    end

    assign grant      = grant_any && ((state_q == IDLE) || complete);
    assign winner_inc = (winner == PW'(N - 1)) ? '0 : winner + PW'(1);

    // Next-state selection for the IDLE/SETUP/ACCESS sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (complete) state_d = grant ? SETUP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, pointer, wait counter and latched APB command.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            wait_q  <= '0;
            psel    <= 1'b0;
            penable <= 1'b0;
            paddr   <= '0;
            pprot   <= '0;
            pwrite  <= 1'b0;
            pwdata  <= '0;
            pstrb   <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                // psel stays high across a back-to-back ACCESS->SETUP hand-over.
                ptr_q   <= winner_inc;
                owner_q <= winner;
                wait_q  <= '0;
                psel    <= 1'b1;
                penable <= 1'b0;
                paddr   <= req_addr[winner*AW +: AW];
                pprot   <= req_prot[winner*3 +: 3];
                pwrite  <= req_write[winner];
                pwdata  <= req_wdata[winner*DW +: DW];
                pstrb   <= req_write[winner] ? req_strb[winner*SW +: SW] : '0;
            end else if (state_q == SETUP) begin
                penable <= 1'b1;
            end else if (complete) begin
                psel    <= 1'b0;
                penable <= 1'b0;
            end else if ((state_q == ACCESS) && !pready && (wait_q != '1)) begin
                // Saturates so TIMEOUT=0 never wraps.
                wait_q <= wait_q + CW'(1);
            end
        end
    end

    // Response is only non-zero in the completion cycle; a timeout forces an error.
    always_comb begin
        done   = '0;
        rdata  = '0;
        slverr = 1'b0;
        if (complete) begin
            done[owner_q] = 1'b1;
            rdata         = timeout_hit ? '0 : prdata;
            slverr        = timeout_hit || pslverr;
        end
    end

endmodule

// File: tb/tb_tvip_apb_arbiter.sv
// Self-checking bench for tvip_apb_arbiter: directed scenarios plus random
// traffic, compared every cycle against a transfer-level reference model.
module tb_tvip_apb_arbiter;

    localparam int N       = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;
    localparam int SW      = DW / 8;

    logic              pclk = 1'b0;
    logic              preset;
    logic [N-1:0]      req;
    logic [N*AW-1:0]   req_addr;
    logic [N-1:0]      req_write;
    logic [N*DW-1:0]   req_wdata;
    logic [N*SW-1:0]   req_strb;
    logic [N*3-1:0]    req_prot;
    logic [N-1:0]      done;
    logic [DW-1:0]     rdata;
    logic              slverr;
    logic              psel;
    logic              penable;
    logic [AW-1:0]     paddr;
    logic [2:0]        pprot;
    logic              pwrite;
    logic [DW-1:0]     pwdata;
    logic [SW-1:0]     pstrb;
    logic              pready;
    logic [DW-1:0]     prdata;
    logic              pslverr;

    tvip_apb_arbiter #(.N(N), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk), .preset(preset), .req(req), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
        .req_prot(req_prot), .done(done), .rdata(rdata), .slverr(slverr),
        .psel(psel), .penable(penable), .paddr(paddr), .pprot(pprot),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pready(pready),
        .prdata(prdata), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Requester side: pending flag plus the command each one presents.
    logic [N-1:0]  pend;
    logic [AW-1:0] c_addr  [N];
    logic          c_write [N];
    logic [DW-1:0] c_wdata [N];
    logic [SW-1:0] c_strb  [N];
    logic [2:0]    c_prot  [N];

    // Reference model: one transfer in flight at most.
    bit            m_busy;
    bit            m_access;
    int            m_owner;
    int            m_ptr;
    int            m_waits;
    logic [AW-1:0] m_addr;
    logic [2:0]    m_prot;
    logic          m_write;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_strb;

    int            done_log[$];
    int            psel_cycles;
    int            pen_cycles;
    logic [DW-1:0] last_rdata;
    logic          last_slverr;
    int            stall;

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req[i]                  = pend[i];
            req_addr[i*AW +: AW]    = c_addr[i];
            req_write[i]            = c_write[i];
            req_wdata[i*DW +: DW]   = c_wdata[i];
            req_strb[i*SW +: SW]    = c_strb[i];
            req_prot[i*3 +: 3]      = c_prot[i];
        end
    endtask

    task automatic issue(input int i, input logic [AW-1:0] a, input logic w,
                         input logic [DW-1:0] d, input logic [SW-1:0] s, input logic [2:0] p);
        pend[i]    = 1'b1;
        c_addr[i]  = a;
        c_write[i] = w;
        c_wdata[i] = d;
        c_strb[i]  = s;
        c_prot[i]  = p;
        drive_reqs();
    endtask

    task automatic new_cmd(input int i);
        issue(i, $urandom, 1'($urandom_range(0, 1)), $urandom,
              SW'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
    endtask

    task automatic model_reset();
        m_busy = 0; m_access = 0; m_owner = 0; m_ptr = 0; m_waits = 0;
        m_addr = '0; m_prot = '0; m_write = 1'b0; m_wdata = '0; m_strb = '0;
        pend = '0;
    endtask

    // Grant to the first set bit of mask at ptr, ptr+1, ... (mod N).
    task automatic model_grant(input logic [N-1:0] mask);
        int  win;
        bit  found;
        win = 0; found = 0;
        for (int k = 0; k < N; k++) begin
            if (!found && mask[(m_ptr + k) % N]) begin
                win = (m_ptr + k) % N;
                found = 1;
            end
        end
        m_ptr    = (win + 1) % N;
        m_owner  = win;
        m_addr   = c_addr[win];
        m_prot   = c_prot[win];
        m_write  = c_write[win];
        m_wdata  = c_wdata[win];
        m_strb   = c_write[win] ? c_strb[win] : '0;
        m_busy   = 1;
        m_access = 0;
        m_waits  = 0;
    endtask

    // One clock: compare at the falling edge, advance model, then new stimulus.
    // mode 0: inputs left to caller; 1: random traffic; 2: every requester always requesting.
    task automatic step(input int mode);
        bit           cmp;
        bit           to;
        int           old_owner;
        logic [N-1:0] mask;
        @(negedge pclk);
        cmp = m_busy && m_access && (pready === 1'b1 || (TIMEOUT > 0 && m_waits == TIMEOUT - 1));
        to  = cmp && (pready !== 1'b1);
        check("psel", psel, m_busy);
        check("penable", penable, m_busy && m_access);
        check("paddr", paddr, m_addr);
        check("pprot", pprot, m_prot);
        check("pwrite", pwrite, m_write);
        check("pwdata", pwdata, m_wdata);
        check("pstrb", pstrb, m_strb);
        check("done", done, cmp ? (64'd1 << m_owner) : 64'd0);
        check("rdata", rdata, (cmp && !to) ? prdata : '0);
        check("slverr", slverr, cmp && (to || pslverr));
        if (psel) psel_cycles++;
        if (penable) pen_cycles++;
        for (int i = 0; i < N; i++) begin
            if (done[i]) begin
                done_log.push_back(i);
                last_rdata  = rdata;
                last_slverr = slverr;
            end
        end
        old_owner = m_owner;
        if (!m_busy) begin
            if (req != 0) model_grant(req);
        end else if (!m_access) begin
            m_access = 1;
        end else if (cmp) begin
            pend[old_owner] = 1'b0;
            mask = req;
            mask[old_owner] = 1'b0;
            if (mask != 0) model_grant(mask);
            else m_busy = 0;
        end else begin
            m_waits++;
        end
        @(posedge pclk);
        #1;
        if (mode == 2) pend = '1;
        if (mode == 1) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) new_cmd(i);
            end
            // Garbage on the owner's command after latching must not matter.
            if (m_busy && m_access && pend[m_owner]) begin
                c_addr[m_owner]  = $urandom;
                c_wdata[m_owner] = $urandom;
                c_write[m_owner] = 1'($urandom_range(0, 1));
            end
            if (stall > 0) begin
                pready = 1'b0;
                stall--;
            end else if ($urandom_range(0, 60) == 0) begin
                stall  = 20;
                pready = 1'b0;
            end else begin
                pready = ($urandom_range(0, 2) != 0);
            end
            prdata  = $urandom;
            pslverr = ($urandom_range(0, 5) == 0);
        end
        drive_reqs();
    endtask

    task automatic drain();
        pready  = 1'b1;
        pslverr = 1'b0;
        for (int k = 0; k < 100 && (m_busy || pend != 0); k++) step(0);
        check("drain_psel", psel, 1'b0);
        check("drain_req", req, '0);
    endtask

    task automatic do_reset();
        preset = 1'b1;
        #1;
        model_reset();
        drive_reqs();
        @(posedge pclk);
        #1;
        preset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        int steps;
        preset  = 1'b1;
        pready  = 1'b0;
        prdata  = '0;
        pslverr = 1'b0;
        stall   = 0;
        for (int i = 0; i < N; i++) begin
            c_addr[i] = '0; c_write[i] = 1'b0; c_wdata[i] = '0; c_strb[i] = '0; c_prot[i] = '0;
        end
        model_reset();
        drive_reqs();
        #12;
        check("rst_psel", psel, 1'b0);
        check("rst_penable", penable, 1'b0);
        check("rst_paddr", paddr, '0);
        check("rst_pwdata", pwdata, '0);
        check("rst_pstrb", pstrb, '0);
        check("rst_done", done, '0);
        check("rst_slverr", slverr, 1'b0);
        @(posedge pclk);
        #1;
        preset = 1'b0;

        // Single write from requester 0.
        pready = 1'b1;
        issue(0, 32'h10, 1'b1, 32'hA5A5_A5A5, 4'hF, 3'd0);
        psel_cycles = 0;
        base = done_log.size();
        for (int k = 0; k < 4; k++) step(0);
        check("w1_psel_cycles", psel_cycles, 2);
        check("w1_done_pulses", done_log.size() - base, 1);
        check("w1_slverr", last_slverr, 1'b0);
        drain();

        // Fairness with all four requesting continuously.
        do_reset();
        for (int i = 0; i < N; i++) issue(i, 32'h100 + 32'(i * 4), 1'(i % 2), 32'(i), 4'h3, 3'(i));
        pready = 1'b1;
        base = done_log.size();
        psel_cycles = 0;
        steps = 0;
        while (done_log.size() < base + 5 && steps < 40) begin
            step(2);
            steps++;
        end
        check("rr_count", done_log.size() - base >= 5, 1'b1);
        for (int k = 0; k < 5; k++) begin
            if (done_log.size() > base + k) check("rr_order", done_log[base + k], k % N);
        end
        check("rr_psel_cont", psel_cycles, steps - 1);
        drain();

        // Read with three wait states.
        issue(1, 32'h2000, 1'b0, 32'hDEAD_BEEF, 4'hF, 3'd2);
        prdata = 32'h1234_5678;
        pen_cycles = 0;
        base = done_log.size();
        for (int k = 0; k < 20 && done_log.size() == base; k++) begin
            pready = (pen_cycles >= 3);
            step(0);
        end
        check("ws_done", done_log.size() - base, 1);
        check("ws_access_cycles", pen_cycles, 4);
        check("ws_rdata", last_rdata, 32'h1234_5678);
        drain();

        // Timeout with pready stuck low.
        issue(2, 32'h3000, 1'b1, 32'h0BAD_F00D, 4'h5, 3'd1);
        pready = 1'b0;
        prdata = 32'hFFFF_FFFF;
        pen_cycles = 0;
        base = done_log.size();
        for (int k = 0; k < 40 && done_log.size() == base; k++) step(0);
        check("to_done", done_log.size() - base, 1);
        check("to_access_cycles", pen_cycles, TIMEOUT);
        check("to_slverr", last_slverr, 1'b1);
        check("to_rdata", last_rdata, '0);
        drain();

        // Asynchronous reset in the middle of ACCESS (ptr was 3 after granting 2).
        issue(2, 32'h4000, 1'b0, 32'h0, 4'h0, 3'd0);
        pready = 1'b0;
        for (int k = 0; k < 3; k++) step(0);
        #2;
        preset = 1'b1;
        #1;
        check("ar_psel", psel, 1'b0);
        check("ar_penable", penable, 1'b0);
        check("ar_done", done, '0);
        check("ar_paddr", paddr, '0);
        model_reset();
        drive_reqs();
        @(posedge pclk);
        #1;
        preset = 1'b0;
        issue(2, 32'h5000, 1'b1, 32'h5555_AAAA, 4'hC, 3'd4);
        issue(3, 32'h6000, 1'b1, 32'h6666_0000, 4'h3, 3'd5);
        pready = 1'b1;
        base = done_log.size();
        for (int k = 0; k < 10 && done_log.size() == base; k++) step(0);
        check("ar_first_grant", (done_log.size() > base) ? done_log[base] : -1, 2);
        drain();

        // Slave error passthrough.
        issue(3, 32'h7000, 1'b0, 32'h0, 4'h0, 3'd3);
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'hCAFE_0001;
        base = done_log.size();
        for (int k = 0; k < 10 && done_log.size() == base; k++) step(0);
        check("se_slverr", last_slverr, 1'b1);
        check("se_rdata", last_rdata, 32'hCAFE_0001);
        drain();

        // Random traffic.
        for (int k = 0; k < 600; k++) step(1);
        stall = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
